frequency_divider: RTL and testbench

Programmable clock-enable-driven frequency divider producing a registered square wave from the single system clock. The block sits between the system clock domain and any logic needing a slow periodic strobe or clock-like reference (LED blink, sampling strobes, bench stimulus). Period and high time are runtime-loadable with glitch-free updates at period boundaries.

---
 rtl/freq_divider_pkg.sv | 23 ++
 rtl/freq_divider_shadow.sv | 81 ++++++++
 rtl/frequency_divider.sv | 94 +++++++++
 tb/tb_frequency_divider.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_divider_pkg.sv
// freq_divider_pkg
//   Shared types and helpers for the frequency divider slice.
//   CNT_W_DEFAULT : default counter / period width.
//   cnt_t         : counter-width vector at the package width.
//   clamp_period  : period values 0 or 1 become 2.
//   clamp_high    : high time is limited to the effective period (constant high).
//   The helpers operate at the package width. Overriding CNT_W above
//   CNT_W_DEFAULT requires raising CNT_W_DEFAULT as well.
package freq_divider_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;

    typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

    function automatic cnt_t clamp_period(input cnt_t p);
        return (p < cnt_t'(2)) ? cnt_t'(2) : p;
    endfunction

    function automatic cnt_t clamp_high(input cnt_t h, input cnt_t p_eff);
        return (h > p_eff) ? p_eff : h;
    endfunction

endpackage

// File: rtl/freq_divider_shadow.sv
// freq_divider_shadow
//   Owns the active period/high registers, the shadow copies and the pending
//   flag. New settings are only ever applied on a period boundary.
//   Build option: FREQ_DIVIDER_DUTY_EN adds i_high; without it the high
//   time is period >> 1.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_boundary    : enabled edge at terminal count (apply point)
//   i_load        : one-cycle capture request
//   i_period      : requested period
//   i_high        : requested high time (FREQ_DIVIDER_DUTY_EN only)
//   o_per_a       : active period
//   o_hi_a        : active high time
//   o_hi_next     : high time that becomes active if this edge is a boundary
module freq_divider_shadow
    import freq_divider_pkg::*;
#(
    parameter int unsigned CNT_W          = CNT_W_DEFAULT,
    parameter int unsigned DEFAULT_PERIOD = 10,
    parameter int unsigned HI_RST         = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_boundary,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_period,
`ifdef FREQ_DIVIDER_DUTY_EN
    input  logic [CNT_W-1:0] i_high,
`endif
    output logic [CNT_W-1:0] o_per_a,
    output logic [CNT_W-1:0] o_hi_a,
    output logic [CNT_W-1:0] o_hi_next
);

    logic [CNT_W-1:0] r_per_a, r_hi_a, r_per_s, r_hi_s;
    logic             r_pend;
    logic [CNT_W-1:0] w_per_in, w_hi_in, w_per_next, w_hi_next;

    assign w_per_in = CNT_W'(clamp_period(cnt_t'(i_period)));
`ifdef FREQ_DIVIDER_DUTY_EN
    assign w_hi_in  = CNT_W'(clamp_high(cnt_t'(i_high), cnt_t'(w_per_in)));
`else
    assign w_hi_in  = w_per_in >> 1;
`endif

    // A load on the boundary edge itself beats any older pending value.
    always_comb begin
        w_per_next = r_per_a;
        w_hi_next  = r_hi_a;
        if (i_load) begin
            w_per_next = w_per_in;
            w_hi_next  = w_hi_in;
        end else if (r_pend) begin
            w_per_next = r_per_s;
            w_hi_next  = r_hi_s;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_per_a <= CNT_W'(DEFAULT_PERIOD);
            r_hi_a  <= CNT_W'(HI_RST);
            r_per_s <= '0;
            r_hi_s  <= '0;
            r_pend  <= 1'b0;
        end else if (i_boundary) begin
            r_per_a <= w_per_next;
            r_hi_a  <= w_hi_next;
            r_pend  <= 1'b0;
        end else if (i_load) begin
            r_per_s <= w_per_in;
            r_hi_s  <= w_hi_in;
            r_pend  <= 1'b1;
        end
    end

    assign o_per_a   = r_per_a;
    assign o_hi_a    = r_hi_a;
    assign o_hi_next = w_hi_next;

endmodule

// File: rtl/frequency_divider.sv
// frequency_divider
//   Programmable divider producing a registered square wave and a
//   start-of-period tick. Period/high changes take effect only at period
//   boundaries, so the output never shows runt pulses.
//   Build option: FREQ_DIVIDER_DUTY_EN adds the high_i port and makes the
//   high time programmable (reset value DEFAULT_HIGH); otherwise the high
//   time is period >> 1.
// Ports:
//   clk         : system clock, rising edge
//   rst         : synchronous active-high reset
//   en          : count enable; counter and output hold while low
//   load_i      : one-cycle request to capture period_i / high_i
//   period_i    : requested period in cycles (0/1 clamp to 2)
//   high_i      : requested high time (FREQ_DIVIDER_DUTY_EN only)
//   square_wave : registered divided output
//   period_tick : registered one-cycle pulse at the start of each period
module frequency_divider
    import freq_divider_pkg::*;
#(
    parameter int unsigned CNT_W          = CNT_W_DEFAULT,
    parameter int unsigned DEFAULT_PERIOD = 10,
    parameter int unsigned DEFAULT_HIGH   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_i,
    input  logic [CNT_W-1:0] period_i,
`ifdef FREQ_DIVIDER_DUTY_EN
    input  logic [CNT_W-1:0] high_i,
`endif
    output logic             square_wave,
    output logic             period_tick
);

`ifdef FREQ_DIVIDER_DUTY_EN
    localparam int unsigned HI_RST = (DEFAULT_HIGH > DEFAULT_PERIOD) ? DEFAULT_PERIOD : DEFAULT_HIGH;
`else
    localparam int unsigned HI_RST = DEFAULT_PERIOD >> 1;
`endif

    logic [CNT_W-1:0] r_cnt;
    logic             r_square, r_tick;
    logic [CNT_W-1:0] w_per_a, w_hi_a, w_hi_next, w_cnt_inc;
    logic             w_boundary;

    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    // cnt == per_a-1 written without the subtraction.
    assign w_boundary = en && (w_cnt_inc == w_per_a);

    freq_divider_shadow #(
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEFAULT_PERIOD),
        .HI_RST         (HI_RST)
    ) u_shadow (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_boundary (w_boundary),
        .i_load     (load_i),
        .i_period   (period_i),
`ifdef FREQ_DIVIDER_DUTY_EN
        .i_high     (high_i),
`endif
        .o_per_a    (w_per_a),
        .o_hi_a     (w_hi_a),
        .o_hi_next  (w_hi_next)
    );

    // cnt is parked at terminal count after reset so the first enabled
    // edge starts a fresh period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= CNT_W'(DEFAULT_PERIOD - 1);
            r_square <= 1'b0;
            r_tick   <= 1'b0;
        end else if (en) begin
            if (w_boundary) begin
                r_cnt    <= '0;
                r_square <= (w_hi_next != '0);
                r_tick   <= 1'b1;
            end else begin
                r_cnt    <= w_cnt_inc;
                r_square <= (w_cnt_inc < w_hi_a);
                r_tick   <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign square_wave = r_square;
    assign period_tick = r_tick;

endmodule

// File: tb/tb_frequency_divider.sv
// tb_frequency_divider
//   Directed bench for frequency_divider, default parameters (10/5).
//   Works with or without FREQ_DIVIDER_DUTY_EN defined.
module tb_frequency_divider;

    localparam int DP = 10;
`ifdef FREQ_DIVIDER_DUTY_EN
    localparam int DH = 5;
`else
    localparam int DH = DP / 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        load_i = 1'b0;
    logic [15:0] period_i = '0;
`ifdef FREQ_DIVIDER_DUTY_EN
    logic [15:0] high_i = '0;
`endif
    logic        square_wave, period_tick;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    frequency_divider #(
        .CNT_W          (16),
        .DEFAULT_PERIOD (10),
        .DEFAULT_HIGH   (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load_i      (load_i),
        .period_i    (period_i),
`ifdef FREQ_DIVIDER_DUTY_EN
        .high_i      (high_i),
`endif
        .square_wave (square_wave),
        .period_tick (period_tick)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase k within the current period, active period/high,
    // one pending slot. Output is simply "phase below high time".
    int mP = DP, mH = DH, mk = DP - 1, ppP = 0, ppH = 0;
    bit mpend = 1'b0, mfresh = 1'b1, mtick = 1'b0;

    always @(posedge clk) begin : model
        int  p_in, h_in;
        bit  bnd;
        p_in = (int'(period_i) < 2) ? 2 : int'(period_i);
`ifdef FREQ_DIVIDER_DUTY_EN
        h_in = int'(high_i);
`else
        h_in = p_in / 2;
`endif
        if (rst) begin
            mP = DP; mH = DH; mk = DP - 1;
            mpend = 1'b0; mfresh = 1'b1; mtick = 1'b0;
        end else begin
            bnd = en && (mk == mP - 1);
            if (bnd) begin
                if (load_i) begin
                    mP = p_in; mH = h_in;
                end else if (mpend) begin
                    mP = ppP; mH = ppH;
                end
                mpend = 1'b0; mk = 0; mtick = 1'b1; mfresh = 1'b0;
            end else begin
                if (load_i) begin
                    ppP = p_in; ppH = h_in; mpend = 1'b1;
                end
                if (en) begin
                    mk++;
                    mfresh = 1'b0;
                end
                mtick = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_sq", {31'd0, square_wave}, {31'd0, (!mfresh && (mk < mH))});
            check("model_tick", {31'd0, period_tick}, {31'd0, mtick});
        end
    end

    initial begin
        logic [19:0] bits20;
        logic [13:0] bits14;
        logic [19:0] dflt_wave;
        logic [13:0] exp14;
        int   ticks, highs;
        bit   seen;

        dflt_wave = 20'b00000111110000011111;
`ifdef FREQ_DIVIDER_DUTY_EN
        exp14 = 14'b00010001000001;
`else
        exp14 = 14'b00110011000001;
`endif

        // Reset, then defaults: 5 high / 5 low, tick every 10.
        rst = 1'b1; en = 1'b1;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        check("reset_sq", {31'd0, square_wave}, 32'd0);
        check("reset_tick", {31'd0, period_tick}, 32'd0);
        rst = 1'b0;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bits20[i] = square_wave;
            if (i == 0) check("first_tick", {31'd0, period_tick}, 32'd1);
            ticks += int'(period_tick);
        end
        check("dflt_wave", {12'd0, bits20}, {12'd0, dflt_wave});
        check("dflt_ticks", ticks, 2);

        // Mid-period load of 4/1: current period finishes first.
        repeat (3) @(negedge clk);
        load_i = 1'b1; period_i = 16'd4;
`ifdef FREQ_DIVIDER_DUTY_EN
        high_i = 16'd1;
`endif
        @(negedge clk);
        load_i = 1'b0;
        ticks = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            bits14[i] = square_wave;
            ticks += int'(period_tick);
        end
        check("load4_wave", {18'd0, bits14}, {18'd0, exp14});
        check("load4_ticks", ticks, 2);

        // Enable low for 7 cycles during the high phase.
        @(negedge clk);
        check("pre_hold_sq", {31'd0, square_wave}, 32'd1);
        en = 1'b0;
        ticks = 0; highs = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            highs += int'(square_wave);
            ticks += int'(period_tick);
        end
        check("hold_highs", highs, 7);
        check("hold_ticks", ticks, 0);
        en = 1'b1;
        @(negedge clk);
`ifdef FREQ_DIVIDER_DUTY_EN
        check("resume_sq", {31'd0, square_wave}, 32'd0);
`else
        check("resume_sq", {31'd0, square_wave}, 32'd1);
`endif

        // Period 1 clamps to 2; high 0 gives constant low with duty control.
        load_i = 1'b1; period_i = 16'd1;
`ifdef FREQ_DIVIDER_DUTY_EN
        high_i = 16'd0;
`endif
        @(negedge clk);
        load_i = 1'b0;
        repeat (6) @(negedge clk);
        ticks = 0; highs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            highs += int'(square_wave);
            ticks += int'(period_tick);
        end
        check("p2_ticks", ticks, 4);
`ifdef FREQ_DIVIDER_DUTY_EN
        check("p2_highs", highs, 0);
`else
        check("p2_highs", highs, 4);
`endif

        // Period 6, high 9: constant high with duty control.
        load_i = 1'b1; period_i = 16'd6;
`ifdef FREQ_DIVIDER_DUTY_EN
        high_i = 16'd9;
`endif
        @(negedge clk);
        load_i = 1'b0;
        repeat (8) @(negedge clk);
        ticks = 0; highs = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            highs += int'(square_wave);
            ticks += int'(period_tick);
        end
        check("p6_ticks", ticks, 2);
`ifdef FREQ_DIVIDER_DUTY_EN
        check("p6_highs", highs, 12);
`else
        check("p6_highs", highs, 6);
`endif

        // Reset mid-high with a pending load: defaults return, load discarded.
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = period_tick;
        end
        check("tick_seen", {31'd0, seen}, 32'd1);
        load_i = 1'b1; period_i = 16'd20;
`ifdef FREQ_DIVIDER_DUTY_EN
        high_i = 16'd3;
`endif
        @(negedge clk);
        load_i = 1'b0;
        check("pre_rst_sq", {31'd0, square_wave}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_sq", {31'd0, square_wave}, 32'd0);
        check("rst2_tick", {31'd0, period_tick}, 32'd0);
        rst = 1'b0;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bits20[i] = square_wave;
            ticks += int'(period_tick);
        end
        check("rst2_wave", {12'd0, bits20}, {12'd0, dflt_wave});
        check("rst2_ticks", ticks, 2);

        chk_on = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
